fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, 8, program counter and instruction-memory address width.
REQ-002 Parameter INSTR_W, 8, instruction width: [7:4] opcode, [3:0] operand.
REQ-003 Parameter RESET_PC, 0, PC value loaded on reset.
REQ-004 Parameter ACK_TIMEOUT, 16, maximum FETCH cycles allowed while waiting for imem_ack.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 Clk  in  1  clock; all state updates on its rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 imem_req  out  1  instruction-memory read request.
REQ-009 imem_addr  out  PC_W  read address; equals PC.
REQ-010 imem_ack  in  1  read-data valid.
REQ-011 imem_rdata  in  INSTR_W  instruction word.
REQ-012 Opcode  out  4  opcode to the controller FSM; 4'b0000 (NOP) unless ir_valid.
REQ-013 Operand  out  4  IR[3:0], held between fetches.
REQ-014 ir_valid  out  1  high for exactly one cycle per fetched instruction (EXEC).
REQ-015 LoadIR, IncPC, SelPC, LoadPC  in  1 each  registered controller outputs.
REQ-016 RegData  in  PC_W  register-file read value used as jump target.
REQ-017 resume  in  1  single-cycle pulse that restarts from HALTED.
REQ-018 PC  out  PC_W  current program counter.
REQ-019 halted  out  1  high while in HALTED.
REQ-020 fault  out  1  sticky ack-timeout flag.

Function
REQ-021 The FSM SHALL have the states IDLE, FETCH, EXEC, UPDATE, HALTED and FAULT.
REQ-022 IDLE SHALL go to FETCH on the first clock edge after reset_n is released.
REQ-023 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal PC, both stable until acknowledged.
REQ-024 In FETCH, imem_ack=1 SHALL load IR from imem_rdata and move the FSM to EXEC.
REQ-025 imem_ack outside FETCH SHALL be ignored.
REQ-026 The wait counter SHALL clear on FETCH entry and increment each FETCH cycle without ack.
REQ-027 An ack arriving on the ACK_TIMEOUT-th FETCH cycle SHALL be accepted.
REQ-028 No ack by the ACK_TIMEOUT-th FETCH cycle SHALL put the FSM in FAULT: fault=1, imem_req=0; exit only by reset.
REQ-029 In EXEC: ir_valid=1, Opcode=IR[7:4], next state UPDATE; this is a single cycle.
REQ-030 In UPDATE, the controller inputs SHALL be sampled and applied in priority order:
- LoadIR=0: PC unchanged, next state HALTED.
- Else LoadPC=1: PC <= SelPC ? zero-extended Operand : RegData; next state FETCH.
- Else IncPC=1: PC <= PC+1 modulo 2^PC_W (PC=all-ones wraps to 0); next state FETCH.
- Else: PC unchanged; next state FETCH (refetch the same address).
REQ-031 LoadPC=1 together with IncPC=1 SHALL jump; the increment is not applied.
REQ-032 Latency with a same-cycle ack SHALL be 3 cycles per instruction: FETCH, EXEC, UPDATE.
REQ-033 In HALTED: halted=1, imem_req=0, PC held.
REQ-034 resume=1 in HALTED SHALL set PC <= PC+1 (wrapping) and move to FETCH; resume in any other state SHALL be ignored.
REQ-035 Controller inputs SHALL be ignored outside UPDATE.

Reset
REQ-036 reset_n=0 SHALL immediately force: state IDLE, PC=RESET_PC, IR=0, counter=0, imem_req=0, ir_valid=0, Opcode=0, Operand=0, halted=0, fault=0.
REQ-037 A reset asserted mid-FETCH SHALL drop imem_req at once; a later stale ack SHALL not load IR.
REQ-038 fault and halted SHALL clear only on reset.

Verification
REQ-039 Reset release, imem_rdata=8'h1D, ack on the first FETCH cycle -> IR=8'h1D, ir_valid pulses in cycle 2 with Opcode=4'hD and Operand=4'hD; with IncPC=1 in UPDATE, PC=1 and the next fetch starts in cycle 4.
REQ-040 PC=8'h10, IR=8'h75, UPDATE inputs LoadPC=1, SelPC=1 -> PC=8'h05; SelPC=0 with RegData=8'hA0 -> PC=8'hA0.
REQ-041 PC=8'hFF, IncPC=1 -> PC=8'h00, imem_addr=8'h00.
REQ-042 Opcode 4'hF, LoadIR=0 -> halted=1, imem_req=0 and PC holds for 10 cycles; resume pulse -> PC+1 fetched.
REQ-043 Ack withheld -> ack on cycle 16 accepted; in a separate run with no ack, fault=1 after cycle 16 and imem_req=0.
REQ-044 reset_n=0 for 1 cycle mid-FETCH at PC=8'h22 -> PC=RESET_PC, imem_req=0 immediately, refetch from 0.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with PC/IR, ack timeout, halt/resume
module fetch_unit #(
    parameter int              PC_W        = 8,
    parameter int              INSTR_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              ACK_TIMEOUT = 16
) (
    input  logic               Clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [3:0]         Opcode,
    output logic [3:0]         Operand,
    output logic               ir_valid,
    input  logic               LoadIR,
    input  logic               IncPC,
    input  logic               SelPC,
    input  logic               LoadPC,
    input  logic [PC_W-1:0]    RegData,
    input  logic               resume,
    output logic [PC_W-1:0]    PC,
    output logic               halted,
    output logic               fault
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic [2:0]         state;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic [CNT_W-1:0]   wait_cnt;
    logic               last_wait;

    // The final permitted FETCH cycle is the one where the counter reads ACK_TIMEOUT-1.
    assign last_wait = (wait_cnt == CNT_W'(ACK_TIMEOUT - 1));

    // Main FSM together with PC and IR updates.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= S_EXEC;
                    end else if (last_wait) begin
                        state <= S_FAULT;
                    end
                end
                S_EXEC: state <= S_UPDATE;
                S_UPDATE: begin
                    if (!LoadIR) begin
                        state <= S_HALTED;
                    end else begin
                        state <= S_FETCH;
                        // A jump takes priority over an increment requested in the same cycle.
                        if (LoadPC) begin
                            pc <= SelPC ? {{(PC_W-4){1'b0}}, ir[3:0]} : RegData;
                        end else if (IncPC) begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                end
                S_HALTED: begin
                    if (resume) begin
                        pc    <= pc + PC_W'(1);
                        state <= S_FETCH;
                    end
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_FAULT;
            endcase
        end
    end

    // Wait counter: held at zero outside FETCH so every FETCH entry starts from zero.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == S_FETCH && !imem_ack && !last_wait) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Outputs decode straight from registered state so reset removes them immediately.
    always_comb begin
        imem_req  = (state == S_FETCH);
        imem_addr = pc;
        PC        = pc;
        ir_valid  = (state == S_EXEC);
        Opcode    = (state == S_EXEC) ? ir[7:4] : 4'b0000;
        Operand   = ir[3:0];
        halted    = (state == S_HALTED);
        fault     = (state == S_FAULT);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
module tb_fetch_unit;

    logic       Clk = 1'b0;
    logic       reset_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [3:0] Opcode;
    logic [3:0] Operand;
    logic       ir_valid;
    logic       LoadIR, IncPC, SelPC, LoadPC;
    logic [7:0] RegData;
    logic       resume;
    logic [7:0] PC;
    logic       halted;
    logic       fault;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_pc;
    logic       exp_halt;

    fetch_unit #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00), .ACK_TIMEOUT(16)) dut (
        .Clk(Clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .Opcode(Opcode), .Operand(Operand),
        .ir_valid(ir_valid), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
        .RegData(RegData), .resume(resume), .PC(PC), .halted(halted), .fault(fault)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic noise();
        LoadIR  = 1'($urandom);
        IncPC   = 1'($urandom);
        SelPC   = 1'($urandom);
        LoadPC  = 1'($urandom);
        RegData = 8'($urandom);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = 8'h00; resume = 1'b0;
        noise();
        tick();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_pc", PC, 8'h00);
        chk("rst_outs", {ir_valid, Opcode, Operand, halted, fault}, 11'd0);
        reset_n = 1'b1;
        chk("idle_req", imem_req, 1'b0);
        tick();
        chk("first_fetch", {imem_req, imem_addr}, {1'b1, 8'h00});
        exp_pc = 8'h00; exp_halt = 1'b0;
    endtask

    // One instruction starting at the first FETCH cycle: d cycles without ack, then ack.
    task automatic do_instr(input int d, input logic [7:0] data, input logic lir,
                            input logic lpc, input logic spc, input logic inc,
                            input logic [7:0] rd);
        chk("fetch_req", {imem_req, imem_addr}, {1'b1, exp_pc});
        for (int i = 0; i < d; i++) begin
            imem_ack = 1'b0; imem_rdata = 8'($urandom); resume = 1'($urandom);
            noise();
            tick();
            chk("wait_req", {fault, imem_req, imem_addr}, {1'b0, 1'b1, exp_pc});
        end
        imem_ack = 1'b1; imem_rdata = data; resume = 1'($urandom);
        noise();
        tick();
        chk("exec", {ir_valid, imem_req, Opcode, Operand}, {1'b1, 1'b0, data});
        imem_ack = 1'($urandom); imem_rdata = ~data; resume = 1'($urandom);
        noise();
        tick();
        chk("update", {ir_valid, Opcode, Operand, PC}, {1'b0, 4'h0, data[3:0], exp_pc});
        imem_ack = 1'($urandom); imem_rdata = ~data; resume = 1'($urandom);
        LoadIR = lir; LoadPC = lpc; SelPC = spc; IncPC = inc; RegData = rd;
        tick();
        if (!lir) exp_halt = 1'b1;
        else if (lpc) exp_pc = spc ? {4'h0, data[3:0]} : rd;
        else if (inc) exp_pc = exp_pc + 8'd1;
        imem_ack = 1'b0; resume = 1'b0;
        noise();
        chk("post_update", {halted, imem_req, PC}, {exp_halt, ~exp_halt, exp_pc});
    endtask

    task automatic do_halt(input int n);
        for (int i = 0; i < n; i++) begin
            imem_ack = 1'($urandom); imem_rdata = 8'($urandom);
            noise();
            tick();
            chk("halt_hold", {halted, imem_req, PC}, {1'b1, 1'b0, exp_pc});
        end
        resume = 1'b1; imem_ack = 1'b0;
        tick();
        resume = 1'b0;
        exp_pc = exp_pc + 8'd1; exp_halt = 1'b0;
        chk("resumed", {halted, imem_req, imem_addr}, {1'b0, 1'b1, exp_pc});
    endtask

    initial begin
        do_reset();

        // Basic first instruction with same-cycle ack and increment.
        do_instr(0, 8'h1D, 1, 0, 0, 1, 8'h00);
        chk("pc_one", PC, 8'h01);

        // Jump to 0x10, then operand jump to 0x05, then register jump to 0xA0.
        do_instr(0, 8'h20, 1, 1, 0, 1, 8'h10);
        do_instr(1, 8'h75, 1, 1, 1, 1, 8'h33);
        chk("sel_operand", PC, 8'h05);
        do_instr(2, 8'h75, 1, 1, 0, 0, 8'hA0);
        chk("sel_regdata", PC, 8'hA0);

        // Wrap from 0xFF and refetch with no control input.
        do_instr(0, 8'h00, 1, 1, 0, 0, 8'hFF);
        do_instr(0, 8'h31, 1, 0, 0, 1, 8'h00);
        chk("wrap", imem_addr, 8'h00);
        do_instr(0, 8'h42, 1, 0, 0, 0, 8'h00);

        // Ack on the last permitted FETCH cycle.
        do_instr(15, 8'h5A, 1, 0, 0, 1, 8'h00);

        // Halt for 10 cycles, then resume.
        do_instr(0, 8'hF0, 0, 1, 1, 1, 8'h77);
        do_halt(10);

        // Randomized instruction stream.
        for (int k = 0; k < 60; k++) begin
            int d;
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            do_instr(d, 8'($urandom), ($urandom_range(0, 5) != 0), 1'($urandom),
                     1'($urandom), 1'($urandom), 8'($urandom));
            if (exp_halt) do_halt($urandom_range(1, 10));
        end

        // Reset in the middle of FETCH at 0x22 with a stale ack.
        do_instr(0, 8'h11, 1, 1, 0, 0, 8'h22);
        imem_ack = 1'b0;
        tick();
        chk("pre_rst_fetch", {imem_req, imem_addr}, {1'b1, 8'h22});
        reset_n = 1'b0; imem_ack = 1'b1; imem_rdata = 8'hEE;
        #1;
        chk("rst_async", {imem_req, PC, Operand}, {1'b0, 8'h00, 4'h0});
        @(negedge Clk);
        reset_n = 1'b1;
        tick();
        chk("stale_ack", {imem_req, imem_addr, ir_valid, Operand}, {1'b1, 8'h00, 1'b0, 4'h0});
        imem_ack = 1'b0;
        exp_pc = 8'h00; exp_halt = 1'b0;
        do_instr(0, 8'h9C, 1, 0, 0, 1, 8'h00);

        // Timeout: no ack for 16 FETCH cycles.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            imem_ack = 1'b0;
            tick();
            if (i < 16) chk("to_wait", {fault, imem_req}, {1'b0, 1'b1});
        end
        chk("to_fault", {fault, imem_req}, {1'b1, 1'b0});
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'b1; resume = 1'b1;
            noise();
            tick();
        end
        chk("fault_sticky", {fault, imem_req, ir_valid, halted}, {1'b1, 1'b0, 1'b0, 1'b0});
        resume = 1'b0; imem_ack = 1'b0;
        do_reset();
        chk("fault_cleared", fault, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
